// File: rtl/ads_bus_pkg.sv
// Shared ADS serial-bus definitions: arbiter state encoding, frame line levels
// and a one-hot to index helper.
package ads_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ADDR,
        DECODE,
        ACK0,
        ACK1,
        XFER,
        RELEASE
    } arb_state_t;

    localparam logic FRAME_IDLE  = 1'b1;
    localparam logic FRAME_START = 1'b0;
    localparam logic ACK         = 1'b1;
    localparam logic NACK        = 1'b0;

    // Supports up to 8 masters; callers zero-extend their one-hot vector.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the search starts one past the last grant and
// wraps, returning a one-hot winner and a valid flag.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  win,
    output logic          valid
);

    logic [IW-1:0] idx;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IW'((int'(last) + off) % N);
            if (!valid && req[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_serial_arbiter.sv
// Round-robin arbiter for N serial masters sharing the ADS address decoder.
// Optional watchdog on DECODE/XFER is enabled by defining ARB_TIMEOUT_EN.
module rr_serial_arbiter
    import ads_bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] m_tx,
    output logic [N_MASTERS-1:0] m_rx,
    output logic [N_MASTERS-1:0] gnt,
    output logic [ADDR_W-1:0]    addr,
    output logic                 addr_rdy,
    input  logic                 slv_ready,
    input  logic                 slv_busy,
    input  logic                 slv_responded,
    output logic                 timeout
);

    localparam int IW = $clog2(N_MASTERS);
    localparam int BW = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(ADDR_W - 1);

    if (N_MASTERS < 2 || N_MASTERS > 8 || ADDR_W < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("rr_serial_arbiter: parameter out of range");
    end

    arb_state_t           state;
    logic [IW-1:0]        last_gnt;
    logic [IW-1:0]        gnt_idx;
    logic [ADDR_W-1:0]    shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 ack;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] pick_win;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic [ADDR_W-1:0]    addr_next;

    assign req       = ~m_tx;
    assign pick_idx  = IW'(onehot_to_idx(8'(pick_win)));
    assign addr_next = ADDR_W'({shreg, m_tx[gnt_idx]});

    rr_pick #(
        .N (N_MASTERS),
        .IW(IW)
    ) u_pick (
        .req  (req),
        .last (last_gnt),
        .win  (pick_win),
        .valid(pick_valid)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;
`endif

    // NOTE: outputs take their idle value first each cycle and the state case
    // overrides them; non-blocking assignment makes the last write win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            m_rx     <= {N_MASTERS{FRAME_IDLE}};
            addr     <= '0;
            addr_rdy <= 1'b0;
            timeout  <= 1'b0;
            last_gnt <= IW'(N_MASTERS - 1);
            shreg    <= '0;
            bit_cnt  <= '0;
            ack      <= NACK;
`ifdef ARB_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
        end else begin
            m_rx     <= {N_MASTERS{FRAME_IDLE}};
            addr_rdy <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt            <= pick_win;
                        gnt_idx        <= pick_idx;
                        m_rx[pick_idx] <= FRAME_START;
                        state          <= GRANT;
                    end
                end
                GRANT: begin
                    bit_cnt <= '0;
                    state   <= ADDR;
                end
                ADDR: begin
                    shreg <= addr_next;
                    if (bit_cnt == LAST_BIT) begin
                        addr     <= addr_next;
                        addr_rdy <= 1'b1;
                        state    <= DECODE;
`ifdef ARB_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    // Busy takes precedence when the decoder reports both at once.
                    if (slv_busy) begin
                        ack           <= NACK;
                        m_rx[gnt_idx] <= FRAME_START;
                        state         <= ACK0;
                    end else if (slv_ready) begin
                        ack           <= ACK;
                        m_rx[gnt_idx] <= FRAME_START;
                        state         <= ACK0;
`ifdef ARB_TIMEOUT_EN
                    end else if (wd_cnt == TW'(TIMEOUT)) begin
                        ack           <= NACK;
                        timeout       <= 1'b1;
                        m_rx[gnt_idx] <= FRAME_START;
                        state         <= ACK0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                ACK0: begin
                    m_rx[gnt_idx] <= ack;
                    state         <= ACK1;
                end
                ACK1: begin
                    if (ack == ACK) begin
                        state  <= XFER;
`ifdef ARB_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end else begin
                        state <= RELEASE;
                    end
                end
                XFER: begin
                    if (slv_responded) begin
                        state <= RELEASE;
`ifdef ARB_TIMEOUT_EN
                    end else if (wd_cnt == TW'(TIMEOUT)) begin
                        timeout <= 1'b1;
                        state   <= RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    gnt      <= '0;
                    last_gnt <= gnt_idx;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_serial_arbiter.sv
// Scoreboard bench for rr_serial_arbiter (N_MASTERS=2, ADDR_W=2): stimulus pushes
// expected grant/address/ack records, a negedge monitor pops and compares them.
module tb_rr_serial_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] m_tx = 2'b11;
    logic [1:0] m_rx;
    logic [1:0] gnt;
    logic [1:0] addr;
    logic       addr_rdy;
    logic       slv_ready = 1'b0;
    logic       slv_busy = 1'b0;
    logic       slv_responded = 1'b0;
    logic       timeout;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0] gnt;
        logic [1:0] addr;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];

    rr_serial_arbiter #(
        .N_MASTERS(2),
        .ADDR_W   (2),
        .TIMEOUT  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_tx         (m_tx),
        .m_rx         (m_rx),
        .gnt          (gnt),
        .addr         (addr),
        .addr_rdy     (addr_rdy),
        .slv_ready    (slv_ready),
        .slv_busy     (slv_busy),
        .slv_responded(slv_responded),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle invariants plus the addr_rdy / ack-frame scoreboard.
    initial begin
        int   phase;
        exp_t cur;
        logic [1:0] want;
        phase = 0;
        cur = '{gnt: 2'b00, addr: 2'b00, ack: 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0;
            end else begin
                check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
                check("ungranted_rx_idle", 32'(m_rx | gnt), 32'd3);
                case (phase)
                    0: if (addr_rdy) begin
                        check("queue_has_entry", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) begin
                            cur = exp_q.pop_front();
                            check("addr_gnt", 32'(gnt), 32'(cur.gnt));
                            check("addr_value", 32'(addr), 32'(cur.addr));
                            phase = 1;
                        end
                    end
                    1: if (m_rx != 2'b11) begin
                        want = ~cur.gnt;
                        check("ack_start_bit", 32'(m_rx), 32'(want));
                        phase = 2;
                    end
                    default: begin
                        want = cur.ack ? 2'b11 : ~cur.gnt;
                        check("ack_value_bit", 32'(m_rx), 32'(want));
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // resp: 0 ready, 1 busy, 2 ready+busy together, 3 no response (watchdog).
    task automatic txn(input int m, input logic [1:0] a, input int resp,
                       input bit keep, input bit toggle);
        exp_t e;
        int   n;
        int   o;
        o = 1 - m;
        e.gnt  = 2'(1 << m);
        e.addr = a;
        e.ack  = (resp == 0);
        exp_q.push_back(e);
        m_tx[m] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_rx[m] !== 1'b0 && n < 40);
        check("grant_strobe", 32'(m_rx[m]), 32'd0);
        @(posedge clk); #1;
        m_tx[m] = a[1];
        @(negedge clk);
        check("grant_strobe_one_cycle", 32'(m_rx[m]), 32'd1);
        @(posedge clk); #1;
        m_tx[m] = a[0];
        @(posedge clk); #1;
        m_tx[m] = keep ? 1'b0 : 1'b1;
        @(negedge clk);
        check("addr_rdy_latency", 32'(addr_rdy), 32'd1);
        @(posedge clk); #1;
        case (resp)
            0: slv_ready = 1'b1;
            1: slv_busy = 1'b1;
            2: begin slv_ready = 1'b1; slv_busy = 1'b1; end
            default: ;
        endcase
        @(posedge clk); #1;
        slv_ready = 1'b0;
        slv_busy  = 1'b0;
        if (resp == 0) begin
            for (int i = 0; i < 4; i++) begin
                if (toggle) m_tx[o] = ~m_tx[o];
                @(negedge clk);
                if (toggle) begin
                    check("xfer_gnt_held", 32'(gnt), 32'(e.gnt));
                    check("xfer_other_rx", 32'(m_rx[o]), 32'd1);
                end
                @(posedge clk); #1;
            end
            if (toggle) m_tx[o] = 1'b1;
            slv_responded = 1'b1;
            @(posedge clk); #1;
            slv_responded = 1'b0;
        end else if (resp == 3) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (timeout !== 1'b1 && n < 40);
            check("timeout_pulse", 32'(timeout), 32'd1);
            @(negedge clk);
            check("timeout_single_cycle", 32'(timeout), 32'd0);
        end else begin
            repeat (3) @(negedge clk);
            @(negedge clk);
            check("nack_release_no_xfer", 32'(gnt), 32'd0);
        end
        n = 0;
        while (gnt !== 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("gnt_released", 32'(gnt), 32'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_m_rx", 32'(m_rx), 32'd3);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_addr_rdy", 32'(addr_rdy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Both masters request together: 0, then 1, then 0 again.
        m_tx[1] = 1'b0;
        txn(0, 2'b11, 0, 1'b1, 1'b0);
        txn(1, 2'b01, 0, 1'b0, 1'b0);
        txn(0, 2'b00, 0, 1'b0, 1'b0);

        // Single request, address 2'b10, full ACK transaction.
        txn(0, 2'b10, 0, 1'b0, 1'b0);

        // Busy and ready together -> NACK; plain busy -> NACK.
        txn(1, 2'b11, 2, 1'b0, 1'b0);
        txn(0, 2'b01, 1, 1'b0, 1'b0);

        // Reset in the middle of the address phase.
        m_tx[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_rx[0] !== 1'b0 && n < 40);
        check("pre_rst_grant", 32'(m_rx[0]), 32'd0);
        @(posedge clk); #1;
        m_tx[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        m_tx[0] = 1'b1;
        @(negedge clk);
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_m_rx", 32'(m_rx), 32'd3);
        check("mid_rst_addr", 32'(addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle_gnt", 32'(gnt), 32'd0);
        check("post_rst_idle_rx", 32'(m_rx), 32'd3);

        // Fresh request after reset, then master 1 toggling during master 0's XFER.
        txn(0, 2'b11, 0, 1'b0, 1'b0);
        txn(0, 2'b10, 0, 1'b0, 1'b1);

`ifdef ARB_TIMEOUT_EN
        txn(1, 2'b00, 3, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/rr_serial_arbiter.md
# rr_serial_arbiter

Round-robin arbiter for the ADS serial bus. It shares the address-decode and slave path between N serial masters. It detects requests on the masters' idle-high tx lines, grants one master, and shifts in that master's serial slave address. It then hands the address to the address decoder, returns a serial ACK/NACK frame to the master, and holds the grant until the decoder reports that the transaction is complete.

## Interface
- N_MASTERS, default 2: number of masters, range 2..8.
- ADDR_W, default 2: width of the serial slave address.
- TIMEOUT, default 1023: watchdog limit in cycles. Used only when ARB_TIMEOUT_EN is defined.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous reset, active-high.
- m_tx  in  N_MASTERS  master serial tx lines; idle 1; a held 0 in IDLE is a request.
- m_rx  out  N_MASTERS  serial grant and response lines to the masters; idle 1.
- gnt  out  N_MASTERS  one-hot grant, or all zero; steers the decoder and read muxes.
- addr  out  ADDR_W  shifted-in slave address; holds its value until the next address is shifted in.
- addr_rdy  out  1  single-cycle pulse: addr is valid.
- slv_ready  in  1  pulse from the decoder: addressed slave accepted.
- slv_busy  in  1  pulse from the decoder: addressed slave busy.
- slv_responded  in  1  pulse from the decoder: transaction finished.
- timeout  out  1  single-cycle pulse: the watchdog aborted a transaction.

## Operation
- States are IDLE, GRANT, ADDR, DECODE, ACK0, ACK1, XFER and RELEASE. All outputs are registered.
- IDLE: if any m_tx[i] is 0, choose the winner by round-robin. The search starts at last_gnt+1 and wraps at N_MASTERS-1 to 0. Set gnt to the winner and go to GRANT. With no request, stay in IDLE.
- GRANT, 1 cycle: drive m_rx[w]=0 as the grant strobe. Go to ADDR.
- ADDR, ADDR_W cycles: sample m_tx[w] once per cycle, MSB first, into a shift register. After the last bit, load addr, pulse addr_rdy and go to DECODE.
- DECODE: wait for a decoder response.
  - slv_ready: ack=1, go to ACK0.
  - slv_busy: ack=0, go to ACK0.
  - Both in the same cycle: busy wins, so ack=0.
- ACK0: m_rx[w]=0 as the start bit. ACK1: m_rx[w]=ack. After ACK1, go to XFER if ack=1, otherwise to RELEASE.
- XFER: gnt is held and m_rx[w] is 1. Wait for slv_responded, then go to RELEASE.
- RELEASE, 1 cycle: gnt is cleared, last_gnt is set to w, then return to IDLE.
- Outside IDLE, m_tx is ignored. Masters that are not granted keep their request asserted.
- A master that still holds m_tx=0 in IDLE after RELEASE is a new request.
- slv_ready, slv_busy and slv_responded are ignored outside the states that consume them.
- At most one gnt bit is ever 1. m_rx of every master that is not granted stays 1.

## Timing
- Reset values: state=IDLE, gnt=0, m_rx all 1, addr=0, addr_rdy=0, timeout=0, last_gnt=N_MASTERS-1. This makes master 0 highest priority after reset.
- Reset asserted in any state returns to IDLE on the next edge with the reset values. No partial frame is emitted afterwards.
- Latency, with request sampled at edge E:
  - GRANT cycle is E+1.
  - Address bits are sampled at edges E+2..E+1+ADDR_W.
  - addr_rdy is high in cycle E+2+ADDR_W.
- Master side: after seeing m_rx=0 at an edge, the master drives the address MSB in the next cycle.
- Decoder response at edge D: ACK0 at D+1, ACK1 at D+2, XFER or RELEASE at D+3.
- Back-to-back transactions: the minimum IDLE dwell between them is one cycle.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to DECODE and to XFER, and counts every cycle in those states.
  - Reaching TIMEOUT in DECODE forces ack=0 and enters ACK0.
  - Reaching TIMEOUT in XFER enters RELEASE.
  - In both cases timeout pulses for 1 cycle.
- ARB_TIMEOUT_EN undefined: no counter. DECODE and XFER wait indefinitely, and timeout is tied to 0.

## Structure
- The shared package ads_bus_pkg holds:
  - the arb_state_t enum;
  - the constants FRAME_IDLE=1'b1, FRAME_START=1'b0, ACK=1'b1 and NACK=1'b0.
- Sub-module rr_pick is combinational. It takes the request vector and last_gnt and returns a one-hot winner plus a valid flag. It is instantiated once.

## Test plan
All scenarios use N_MASTERS=2 and ADDR_W=2.
- Single request: m_tx[0] low, address 2'b10.
  - gnt=01, m_rx[0] low for 1 cycle, addr=2 with addr_rdy at E+4.
  - slv_ready gives m_rx[0] = 0 then 1; slv_responded gives gnt=00.
- Simultaneous requests from both masters held through two transactions: grants go master 0 then master 1. After that, master 0 wins again.
- slv_busy and slv_ready pulsed in the same cycle: m_rx frame is 0,0 (NACK). RELEASE follows immediately without XFER.
- rst asserted during ADDR: gnt=00, m_rx=11 and state=IDLE at the next edge. A fresh request is then granted normally.
- With ARB_TIMEOUT_EN and TIMEOUT=8, no decoder response: NACK frame, timeout pulse, and gnt cleared after RELEASE.
- m_tx[1] toggles during master 0's XFER: no grant change and no m_rx[1] activity.
